// File: rtl/regfile_port_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : regfile_port_sequencer
// Brief   : Shares a register array between core (id 0) and debug (id 1):
//           read rs1/rs2 over shared buses, optional write of rd, response.
//           Define REGFILE_SEQ_RR_EN for round-robin arbitration
//           (default: fixed priority, core first).
// Revision: 1.0
// ============================================================================
module regfile_port_sequencer #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_we,
  input  logic [2*AW-1:0]     req_rs1,
  input  logic [2*AW-1:0]     req_rs2,
  input  logic [2*AW-1:0]     req_rd,
  input  logic [2*XLEN-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [XLEN-1:0]     rsp_rdata1,
  output logic [XLEN-1:0]     rsp_rdata2,
  output logic                rsp_err,
  output logic [NREG-1:0]     reg_store,
  output logic [NREG-1:0]     reg_en_a,
  output logic [NREG-1:0]     reg_en_b,
  output logic [XLEN-1:0]     reg_wdata,
  input  logic [XLEN-1:0]     bus_a,
  input  logic [XLEN-1:0]     bus_b
);

  localparam logic [AW:0]     c_nreg = (AW+1)'(NREG);
  localparam logic [NREG-1:0] c_one  = {{(NREG-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              id_q, id_d;
  logic              we_q, we_d;
  logic [AW-1:0]     rs1_q, rs1_d;
  logic [AW-1:0]     rs2_q, rs2_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata1_q, rdata1_d;
  logic [XLEN-1:0]   rdata2_q, rdata2_d;
  logic              err_q, err_d;

  logic              w_grant;
  logic              w_rs1_ok, w_rs2_ok, w_rd_ok, w_do_write;

  function automatic logic [NREG-1:0] f_onehot(input logic [AW-1:0] idx, input logic en);
    f_onehot = en ? (c_one << idx) : '0;
  endfunction

`ifdef REGFILE_SEQ_RR_EN
  logic last_q, last_d;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    w_grant = (req_valid == 2'b11) ? ~last_q : req_valid[1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= 1'b1;
    else          last_q <= last_d;
  end
`else
  always_comb begin
    w_grant = ~req_valid[0];
  end
`endif

  assign w_rs1_ok   = ({1'b0, rs1_q} < c_nreg);
  assign w_rs2_ok   = ({1'b0, rs2_q} < c_nreg);
  assign w_rd_ok    = ({1'b0, rd_q}  < c_nreg);
  assign w_do_write = we_q && (rd_q != '0) && w_rd_ok;

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    we_d      = we_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    wdata_d   = wdata_q;
    rdata1_d  = rdata1_q;
    rdata2_d  = rdata2_q;
    err_d     = err_q;
`ifdef REGFILE_SEQ_RR_EN
    last_d    = last_q;
`endif
    req_ready = 2'b00;
    rsp_valid = 1'b0;
    reg_en_a  = '0;
    reg_en_b  = '0;
    reg_store = '0;
    reg_wdata = '0;

    case (state_q)
      S_IDLE: begin
        // req_ready is held low while reset is asserted so all outputs read 0.
        if (reset_n && (req_valid != 2'b00)) begin
          req_ready = w_grant ? 2'b10 : 2'b01;
          id_d      = w_grant;
          we_d      = req_we[w_grant];
          rs1_d     = w_grant ? req_rs1[2*AW-1:AW] : req_rs1[AW-1:0];
          rs2_d     = w_grant ? req_rs2[2*AW-1:AW] : req_rs2[AW-1:0];
          rd_d      = w_grant ? req_rd[2*AW-1:AW]  : req_rd[AW-1:0];
          wdata_d   = w_grant ? req_wdata[2*XLEN-1:XLEN] : req_wdata[XLEN-1:0];
`ifdef REGFILE_SEQ_RR_EN
          last_d    = w_grant;
`endif
          state_d   = S_READ;
        end
      end
      S_READ: begin
        reg_en_a = f_onehot(rs1_q, w_rs1_ok);
        reg_en_b = f_onehot(rs2_q, w_rs2_ok);
        rdata1_d = w_rs1_ok ? bus_a : '0;
        rdata2_d = w_rs2_ok ? bus_b : '0;
        err_d    = ~w_rs1_ok | ~w_rs2_ok | (we_q & ~w_rd_ok);
        state_d  = w_do_write ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        reg_store = f_onehot(rd_q, w_do_write);
        reg_wdata = wdata_q;
        state_d   = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      wdata_q  <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      we_q     <= we_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      wdata_q  <= wdata_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      err_q    <= err_d;
    end
  end

  assign rsp_id     = id_q;
  assign rsp_rdata1 = rdata1_q;
  assign rsp_rdata2 = rdata2_q;
  assign rsp_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_port_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_port_sequencer
// Brief   : Randomized scoreboard bench for regfile_port_sequencer against a
//           behavioural register-array model (NREG=24 to reach out-of-range).
// Revision: 1.0
// ============================================================================
module tb_regfile_port_sequencer;

  localparam int XLEN = 32;
  localparam int NREG = 24;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                reset_n = 1'b1;
  logic [1:0]          req_valid, req_ready, req_we;
  logic [2*AW-1:0]     req_rs1, req_rs2, req_rd;
  logic [2*XLEN-1:0]   req_wdata;
  logic                rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [XLEN-1:0]     rsp_rdata1, rsp_rdata2, reg_wdata, bus_a, bus_b;
  logic [NREG-1:0]     reg_store, reg_en_a, reg_en_b;

  bit                  fv  [2];
  bit                  fwe [2];
  logic [AW-1:0]       frs1[2], frs2[2], frd[2];
  logic [XLEN-1:0]     fwd [2];

  assign req_valid = {fv[1], fv[0]};
  assign req_we    = {fwe[1], fwe[0]};
  assign req_rs1   = {frs1[1], frs1[0]};
  assign req_rs2   = {frs2[1], frs2[0]};
  assign req_rd    = {frd[1], frd[0]};
  assign req_wdata = {fwd[1], fwd[0]};

  regfile_port_sequencer #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_rdata1(rsp_rdata1), .rsp_rdata2(rsp_rdata2), .rsp_err(rsp_err),
    .reg_store(reg_store), .reg_en_a(reg_en_a), .reg_en_b(reg_en_b),
    .reg_wdata(reg_wdata), .bus_a(bus_a), .bus_b(bus_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [XLEN-1:0] seed_val(input int i);
    return XLEN'(i) * 32'h9E37_79B9 ^ 32'h1234_5678;
  endfunction

  // Physical register array: drives the buses when enabled, floats to a marker otherwise.
  logic [XLEN-1:0] arr [NREG];
  bit              seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < NREG; i++) arr[i] <= seed_val(i);
      seeded <= 1'b1;
    end else begin
      for (int i = 0; i < NREG; i++) if (reg_store[i]) arr[i] <= reg_wdata;
    end
  end

  always_comb begin
    bus_a = 32'hA5A5_5A5A;
    bus_b = 32'h5A5A_A5A5;
    for (int i = 0; i < NREG; i++) begin
      if (reg_en_a[i]) bus_a = arr[i];
      if (reg_en_b[i]) bus_b = arr[i];
    end
  end

  // Reference model state
  logic [XLEN-1:0] mdl [NREG];
  bit              mdl_last = 1'b1;

  typedef struct {
    bit              id;
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
    bit              err;
    int              acc;
    int              lat;
    bit              seen;
    bit              hold5;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [AW-1:0] rnd_idx();
    if ($urandom_range(0, 7) == 0) return AW'($urandom_range(NREG, 31));
    return AW'($urandom_range(0, NREG - 1));
  endfunction

  task automatic new_req(input int i);
    fv[i]   = 1'b1;
    fwe[i]  = 1'($urandom_range(0, 1));
    frs1[i] = rnd_idx();
    frs2[i] = rnd_idx();
    if (fwe[i]) frd[i] = ($urandom_range(0, 5) == 0) ? AW'(0) : rnd_idx();
    else        frd[i] = AW'($urandom_range(0, NREG - 1));
    fwd[i]  = $urandom;
  endtask

  bit last_win;
  bit hold5_next;

  // Waits for an accept, checks the grant, and predicts the response.
  task automatic do_txn(input bit push, output bit ok);
    int   n;
    bit   win, r1ok, r2ok, rdok, wr;
    exp_t e;
    ok = 1'b1;
    n  = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == 2'b00 && n < 40);
    if (req_ready == 2'b00) begin
      check("accept_timeout", 64'(req_ready), 64'd1);
      ok = 1'b0;
      return;
    end
    if (fv[0] && fv[1]) begin
`ifdef REGFILE_SEQ_RR_EN
      win = ~mdl_last;
`else
      win = 1'b0;
`endif
    end else begin
      win = fv[1];
    end
    check("grant", 64'(req_ready), win ? 64'd2 : 64'd1);
    mdl_last = win;
    r1ok  = (frs1[win] < NREG);
    r2ok  = (frs2[win] < NREG);
    rdok  = (frd[win]  < NREG);
    wr    = fwe[win] && (frd[win] != 0) && rdok;
    e.id    = win;
    e.d1    = r1ok ? mdl[frs1[win]] : '0;
    e.d2    = r2ok ? mdl[frs2[win]] : '0;
    e.err   = !r1ok || !r2ok || (fwe[win] && !rdok);
    e.acc   = cyc;
    e.lat   = wr ? 3 : 2;
    e.seen  = 1'b0;
    e.hold5 = hold5_next;
    if (push) begin
      q.push_back(e);
      if (wr) mdl[frd[win]] = fwd[win];
    end
    last_win = win;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  // Monitor: invariants every cycle, scoreboard compare while a response is shown.
  initial begin
    int hold;
    hold      = 0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rsp_ready = 1'b0;
        continue;
      end
      check("bus_invariants",
            64'($onehot0(reg_en_a) && $onehot0(reg_en_b) && $onehot0(reg_store) &&
                !reg_store[0] && (reg_store != '0 || reg_wdata == '0) &&
                !(rsp_valid && req_ready != 2'b00)), 64'd1);
      if (rsp_valid) begin
        if (q.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          if (!q[0].seen) begin
            check("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
            q[0].seen = 1'b1;
            hold = q[0].hold5 ? 5 : 0;
          end
          check("rsp_id",     64'(rsp_id),     64'(q[0].id));
          check("rsp_rdata1", 64'(rsp_rdata1), 64'(q[0].d1));
          check("rsp_rdata2", 64'(rsp_rdata2), 64'(q[0].d2));
          check("rsp_err",    64'(rsp_err),    64'(q[0].err));
        end
      end
      if (hold > 0) begin
        rsp_ready = 1'b0;
        hold--;
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
      if (rsp_valid && rsp_ready && q.size() > 0) void'(q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit              ok;
    int              n;
    logic [NREG-1:0] exp_st;
    for (int i = 0; i < 2; i++) begin
      fv[i] = 1'b0; fwe[i] = 1'b0; frs1[i] = '0; frs2[i] = '0; frd[i] = '0; fwd[i] = '0;
    end
    for (int i = 0; i < NREG; i++) mdl[i] = seed_val(i);
    hold5_next = 1'b0;
    ok = 1'b1;

    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'(|{req_ready, rsp_valid, rsp_id, rsp_err, rsp_rdata1, rsp_rdata2,
                reg_store, reg_en_a, reg_en_b, reg_wdata}), 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Random traffic; the first transactions keep both requesters valid.
    new_req(0);
    new_req(1);
    for (int k = 0; k < 48 && ok; k++) begin
      hold5_next = (k % 7 == 3);
      do_txn(1'b1, ok);
      if (!ok) break;
      fv[last_win] = 1'b0;
      if (k < 4 || $urandom_range(0, 1) != 0) new_req(int'(last_win));
      if (!fv[!last_win] && $urandom_range(0, 2) == 0) new_req(int'(!last_win));
      if (!fv[0] && !fv[1]) new_req(int'($urandom_range(0, 1)));
    end
    fv[0] = 1'b0;
    fv[1] = 1'b0;
    hold5_next = 1'b0;
    drain();

    // Reset while the write strobe is up: no store, no response.
    if (ok) begin
      fv[0] = 1'b1; fwe[0] = 1'b1; frs1[0] = AW'(1); frs2[0] = AW'(2);
      frd[0] = AW'(7); fwd[0] = 32'hDEAD_BEEF;
      do_txn(1'b0, ok);
      fv[0] = 1'b0;
      n = 0;
      while (reg_store == '0 && n < 6) begin
        @(negedge clk);
        n++;
      end
      exp_st    = '0;
      exp_st[7] = 1'b1;
      check("store_rd7",   64'(reg_store), 64'(exp_st));
      check("store_wdata", 64'(reg_wdata), 64'h0000_0000_DEAD_BEEF);
      reset_n = 1'b0;
      #1;
      check("rst_store_clear", 64'(reg_store), 64'd0);
      check("rst_no_rsp",      64'(rsp_valid), 64'd0);
      mdl_last = 1'b1;
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Core must win first after reset; register 7 must still hold its old value.
      fv[0] = 1'b1; fwe[0] = 1'b0; frs1[0] = AW'(7); frs2[0] = AW'(0); frd[0] = AW'(3);
      new_req(1);
      do_txn(1'b1, ok);
      fv[0] = 1'b0;
      if (ok) do_txn(1'b1, ok);
      fv[1] = 1'b0;
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
